// File: rtl/barrel_shift_stepper_8b_if.sv
// Operand/control bundle between a stepper controller and its barrel shifter.
// The master side drives commands and the slave side returns the latched shifter inputs.
interface barrel_shift_stepper_8b_if;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [7:0] data_in;
    logic       lr_in;
    logic [7:0] a;
    logic       lr;
    logic [2:0] amt;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, loop_en, data_in, lr_in,
        input  a, lr, amt, busy, done
    );

    modport slave (
        input  start, stop, loop_en, data_in, lr_in,
        output a, lr, amt, busy, done
    );
endinterface

// File: rtl/barrel_shift_stepper_8b.sv
// Sweeps the shift amount of a barrel_shifter_lr_8b from 0 to 7, advancing one step per TICK_DIV
// clocks. It can wrap continuously, and it can be aborted with stop.
module barrel_shift_stepper_8b #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input logic                           clk,
    input logic                           reset_n,
    barrel_shift_stepper_8b_if.slave      bus
);

    localparam logic [25:0] TickMax = 26'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e      state_q, state_d;
    logic        start_q;
    logic [7:0]  a_q, a_d;
    logic        lr_q, lr_d;
    logic [2:0]  amt_q, amt_d;
    logic [25:0] tick_q, tick_d;
    logic        launch;
    logic        step;

    assign launch = bus.start & ~start_q;
    assign step   = (tick_q == TickMax);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        lr_d    = lr_q;
        amt_d   = amt_q;
        tick_d  = tick_q;
        case (state_q)
            StIdle: begin
                if (launch && !bus.stop) begin
                    state_d = StRun;
                    a_d     = bus.data_in;
                    lr_d    = bus.lr_in;
                    amt_d   = 3'd0;
                    tick_d  = 26'd0;
                end
            end
            StRun: begin
                // Abort wins over a coincident step.
                if (bus.stop) begin
                    state_d = StIdle;
                    amt_d   = 3'd0;
                    tick_d  = 26'd0;
                end else if (step) begin
                    tick_d = 26'd0;
                    if (amt_q != 3'd7) begin
                        amt_d = amt_q + 3'd1;
                    end else if (bus.loop_en) begin
                        amt_d = 3'd0;
                    end else begin
                        state_d = StFinish;
                    end
                end else begin
                    tick_d = tick_q + 26'd1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // start_q resets high so a start already held at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            start_q <= 1'b1;
            a_q     <= 8'h00;
            lr_q    <= 1'b0;
            amt_q   <= 3'd0;
            tick_q  <= 26'd0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            a_q     <= a_d;
            lr_q    <= lr_d;
            amt_q   <= amt_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.lr   = lr_q;
    assign bus.amt  = amt_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StFinish);

endmodule
